spi_led_pwm: RTL
================

SPI_LED_PWM -- requirements
Module: spi_led_pwm

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, giving the byte width from the SPI receiver and the PWM resolution.
REQ-002 SHALL have port clk, input, 1, system clock; all logic rises on clk.
REQ-003 SHALL have port nreset, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port data, input, DATAWIDTH, received byte; stable while data_rdy is high.
REQ-005 SHALL have port data_rdy, input, 1, byte-valid level from the SPI receiver; asynchronous to clk.
REQ-006 SHALL have port nsel, input, 1, SPI chip select (active-low); asynchronous to clk.
REQ-007 SHALL have ports pwm_r, pwm_g, pwm_b, output, 1 each, LED channel drive.
REQ-008 SHALL have port frame_done, output, 1, one-cycle pulse when a complete R,G,B frame is captured.

Function
REQ-009 SHALL synchronise data_rdy and nsel through two flip-flop stages each before use.
REQ-010 SHALL detect a byte on the synchronised data_rdy rising edge (sync=1, previous=0) and capture data on that edge, i.e. the 3rd clk edge after data_rdy rises.
REQ-011 SHALL sequence bytes with FSM states ST_R -> ST_G -> ST_B -> ST_R; each captured byte is written to the shadow register of the current state and advances the state.
REQ-012 SHALL, on capture in ST_B, set pending=1 and pulse frame_done high for exactly one cycle.
REQ-013 SHALL force the state to ST_R whenever synchronised nsel=1; a partial frame is discarded (pending unchanged, shadow contents are not applied).
REQ-014 SHALL run a free-running DATAWIDTH-bit counter cnt, 0 .. 2^DATAWIDTH-1, wrapping to 0.
REQ-015 SHALL copy all three shadow registers to the active duty registers only on the cycle where cnt wraps to 0 and pending=1, then clear pending in that same cycle.
REQ-016 SHALL let the latest frame win if a second frame completes before the wrap; if a frame completes on the wrap cycle itself, pending stays 1 and that frame is applied at the next wrap.
REQ-017 SHALL drive each pwm_x = (cnt < duty_x) as a registered output; duty 0 gives constant 0, and duty 2^DATAWIDTH-1 gives high for 2^DATAWIDTH-1 of 2^DATAWIDTH cycles.
REQ-018 SHALL ignore data_rdy edges while synchronised nsel=1.

Reset
REQ-019 SHALL, while nreset=0 at a clk edge, clear the following: state=ST_R, shadows=0, active duties=0, cnt=0, pending=0, and both synchroniser chains and the edge-history flop.
REQ-020 SHALL hold pwm_r/g/b=0 and frame_done=0 during reset and in the cycle after release.
REQ-021 SHALL discard any frame in progress when reset is asserted mid-frame.

Configuration
REQ-022 SHALL, when macro SPI_LED_GAMMA_EN is defined, load each active duty as (d*d) >> DATAWIDTH using a full 2*DATAWIDTH-bit product, where d is the shadow value.
REQ-023 SHALL, when SPI_LED_GAMMA_EN is undefined, load each active duty with the shadow value unchanged and instantiate no multiplier.

Structure
REQ-024 SHALL take the state enum (ST_R, ST_G, ST_B) and CHANNELS=3 from shared package spi_led_pkg.
REQ-025 SHALL implement the two-flop synchroniser as sub-module spi_led_sync, instantiated twice.

Verification
REQ-026 SHALL cover: bytes 0x40, 0x80, 0xFF with nsel low -> frame_done pulses once; after the next wrap, pwm_r/g/b high for 64/128/255 of 256 cycles (gamma off).
REQ-027 SHALL cover: bytes 0x10, 0x20, then nsel high, then 0x01, 0x02, 0x03 -> no frame_done for the first pair; duties become 1/2/3.
REQ-028 SHALL cover: two full frames (0x11,0x22,0x33 then 0x44,0x55,0x66) within one PWM period -> only 0x44/0x55/0x66 are applied, and no intermediate period shows 0x11..0x33.
REQ-029 SHALL cover: nreset low after the second byte of a frame -> all outputs 0; the next three bytes form a fresh R,G,B frame.
REQ-030 SHALL cover: gamma on with byte 0x80 on all channels -> duty 0x40; with byte 0xFF -> duty 0xFE.
REQ-031 SHALL cover: duty 0x00 -> pwm constant 0 across a full period, with no glitch at the wrap.

Source files
------------

// File: rtl/spi_led_pkg.sv
// Shared definitions for the SPI-fed RGB LED PWM block: channel count,
// byte-sequencing states and the state-advance helper.
package spi_led_pkg;

    localparam int CHANNELS = 3;

    typedef enum logic [1:0] {
        ST_R = 2'd0,
        ST_G = 2'd1,
        ST_B = 2'd2
    } state_t;

    function automatic state_t next_state(input state_t s);
        case (s)
            ST_R:    return ST_G;
            ST_G:    return ST_B;
            default: return ST_R;
        endcase
    endfunction

endpackage

// File: rtl/spi_led_sync.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module spi_led_sync (
    input  logic clk,
    input  logic nreset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
        end
    end

    assign sync_out = sync_reg;

endmodule

// File: rtl/spi_led_pwm.sv
// SPI-fed RGB LED driver: bytes arrive as R,G,B frames, are shadowed, and are
// applied to three PWM channels at the counter wrap. SPI_LED_GAMMA_EN squares duties.
module spi_led_pwm
    import spi_led_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [DATAWIDTH-1:0] data,
    input  logic                 data_rdy,
    input  logic                 nsel,
    output logic                 pwm_r,
    output logic                 pwm_g,
    output logic                 pwm_b,
    output logic                 frame_done
);

    logic                 rdy_sync;
    logic                 nsel_sync;
    logic                 rdy_prev_reg;
    state_t               state_reg;
    logic                 pending_reg;
    logic                 frame_done_reg;
    logic [DATAWIDTH-1:0] cnt_reg;
    logic                 byte_strobe;
    logic                 frame_cap;
    logic                 apply_frame;
    logic [CHANNELS-1:0]  pwm_vec;

    spi_led_sync u_sync_rdy (
        .clk      (clk),
        .nreset   (nreset),
        .async_in (data_rdy),
        .sync_out (rdy_sync)
    );

    spi_led_sync u_sync_nsel (
        .clk      (clk),
        .nreset   (nreset),
        .async_in (nsel),
        .sync_out (nsel_sync)
    );

    // Bytes are only accepted while the chip is selected.
    assign byte_strobe = rdy_sync & ~rdy_prev_reg & ~nsel_sync;
    assign frame_cap   = byte_strobe && (state_reg == ST_B);
    assign apply_frame = (cnt_reg == {DATAWIDTH{1'b1}}) && pending_reg;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg      <= ST_R;
            rdy_prev_reg   <= 1'b0;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            rdy_prev_reg   <= rdy_sync;
            cnt_reg        <= cnt_reg + 1'b1;
            frame_done_reg <= frame_cap;

            if (nsel_sync) begin
                state_reg <= ST_R;
            end else if (byte_strobe) begin
                state_reg <= next_state(state_reg);
            end

            // A frame finishing on the wrap cycle keeps pending set for the next wrap.
            if (frame_cap) begin
                pending_reg <= 1'b1;
            end else if (apply_frame) begin
                pending_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [DATAWIDTH-1:0] shadow_reg;
        logic [DATAWIDTH-1:0] duty_reg;
        logic [DATAWIDTH-1:0] duty_load;
        logic                 pwm_reg;

`ifdef SPI_LED_GAMMA_EN
        logic [2*DATAWIDTH-1:0] square;
        assign square    = {{DATAWIDTH{1'b0}}, shadow_reg} * {{DATAWIDTH{1'b0}}, shadow_reg};
        assign duty_load = square[2*DATAWIDTH-1:DATAWIDTH];
`else
        assign duty_load = shadow_reg;
`endif

        always_ff @(posedge clk) begin
            if (!nreset) begin
                shadow_reg <= '0;
                duty_reg   <= '0;
                pwm_reg    <= 1'b0;
            end else begin
                if (byte_strobe && (state_reg == state_t'(2'(gi)))) begin
                    shadow_reg <= data;
                end
                if (apply_frame) begin
                    duty_reg <= duty_load;
                end
                pwm_reg <= (cnt_reg < duty_reg);
            end
        end

        assign pwm_vec[gi] = pwm_reg;
    end

    assign pwm_r      = pwm_vec[0];
    assign pwm_g      = pwm_vec[1];
    assign pwm_b      = pwm_vec[2];
    assign frame_done = frame_done_reg;

endmodule
